cpu_sequencer: RTL and testbench

//  Top-level instruction sequencer for the multi-cycle RV32I core; sits directly upstream of datapath_control.

---
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Instruction sequencer for the multi-cycle RV32I core. It fetches each
// instruction as four little-endian bytes over a byte-wide req/ack bus. It
// emits a one-cycle PC-increment strobe, then steps the execution stage
// counter until datapath_control retires the instruction. Bus stalls and
// stage-counter runaways end in a sticky FAULT state that only reset leaves.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH(0) | bus_req high, collecting byte bus_lane of the instruction word
// INC(1)   | single-cycle PC+4 strobe, bus idle
// EXEC(2)  | instr_stg advances/holds until instr_done retires the instr
// FAULT(15)| terminal: bus stall timeout or stage overflow, frozen outputs

module cpu_sequencer #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    input  logic        instr_done,
    input  logic        stg_wait,
    output logic        bus_req,
    output logic [1:0]  bus_lane,
    output logic [3:0]  cpu_state,
    output logic        state,
    output logic [2:0]  instr_stg,
    output logic [31:0] instr,
    output logic        fault
);

    typedef enum logic [3:0] {
        ST_FETCH = 4'd0,
        ST_INC   = 4'd1,
        ST_EXEC  = 4'd2,
        ST_FAULT = 4'd15
    } seq_state_t;

    // Fault is taken on the edge at which the stall count would reach
    // BUS_TIMEOUT, so BUS_TIMEOUT cycles of unanswered request are tolerated.
    localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);
    localparam logic [2:0] STG_MAX  = 3'd7;

    seq_state_t  cur_st;
    seq_state_t  nxt_st;
    logic [1:0]  lane_q;
    logic [1:0]  lane_d;
    logic [2:0]  stg_q;
    logic [2:0]  stg_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [7:0]  tmo_q;
    logic [7:0]  tmo_d;

    // State register and datapath registers; synchronous reset wins over all states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st  <= ST_FETCH;
            lane_q  <= 2'd0;
            stg_q   <= 3'd0;
            instr_q <= 32'h0;
            tmo_q   <= 8'd0;
        end else begin
            cur_st  <= nxt_st;
            lane_q  <= lane_d;
            stg_q   <= stg_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state, byte capture, stage stepping and bus stall counting.
    always_comb begin
        nxt_st  = cur_st;
        lane_d  = lane_q;
        stg_d   = stg_q;
        instr_d = instr_q;
        tmo_d   = 8'd0;
        unique case (cur_st)
            ST_FETCH: begin
                if (bus_ack) begin
                    instr_d[{lane_q, 3'b000} +: 8] = bus_rdata;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        nxt_st = ST_INC;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    nxt_st = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_INC: begin
                nxt_st = ST_EXEC;
                stg_d  = 3'd0;
            end
            ST_EXEC: begin
                if (instr_done) begin
                    nxt_st = ST_FETCH;
                    stg_d  = 3'd0;
                    lane_d = 2'd0;
                end else if (stg_wait) begin
                    stg_d = stg_q;
                end else if (stg_q == STG_MAX) begin
                    // Runaway (e.g. unimplemented opcode): trap rather than wrap.
                    nxt_st = ST_FAULT;
                end else begin
                    stg_d = stg_q + 3'd1;
                end
            end
            ST_FAULT: begin
                nxt_st = ST_FAULT;
            end
            default: begin
                nxt_st = ST_FAULT;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so no input reaches an output combinationally.
    always_comb begin
        bus_req   = (cur_st == ST_FETCH);
        state     = (cur_st == ST_INC);
        fault     = (cur_st == ST_FAULT);
        cpu_state = cur_st;
        bus_lane  = lane_q;
        instr_stg = stg_q;
        instr     = instr_q;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed fetch/exec sequences with a scoreboard
// holding the instruction word expected at each PC-increment strobe.
`timescale 1ns/1ps

module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_ack = 1'b0;
    logic        instr_done = 1'b0;
    logic        stg_wait = 1'b0;
    logic        bus_req;
    logic [1:0]  bus_lane;
    logic [3:0]  cpu_state;
    logic        state;
    logic [2:0]  instr_stg;
    logic [31:0] instr;
    logic        fault;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] model_instr = 32'h0;
    logic [31:0] exp_q[$];

    cpu_sequencer #(.BUS_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .instr_done(instr_done), .stg_wait(stg_wait), .bus_req(bus_req),
        .bus_lane(bus_lane), .cpu_state(cpu_state), .state(state),
        .instr_stg(instr_stg), .instr(instr), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the PC-increment strobe is where a fetched word is complete.
    always @(negedge clk) begin
        if (rst_n && cpu_state == 4'd1) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_instr", instr, exp_q.pop_front());
        end
    end

    task automatic chk_reset();
        chk("rst_cpu_state", cpu_state, 0);
        chk("rst_lane", bus_lane, 0);
        chk("rst_stg", instr_stg, 0);
        chk("rst_instr", instr, 0);
        chk("rst_state", state, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", bus_req, 1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        chk_reset();
        rst_n = 1'b1;
        bus_ack = 1'b0;
        instr_done = 1'b0;
        stg_wait = 1'b0;
        model_instr = 32'h0;
    endtask

    // One byte, w unanswered request cycles first (instr_done held high there to show it is ignored).
    task automatic fetch_byte(input int lane, input logic [7:0] b, input int w);
        for (int i = 0; i <= w; i++) begin
            chk("fetch_state", cpu_state, 0);
            chk("fetch_lane", bus_lane, lane);
            chk("fetch_req", bus_req, 1);
            chk("fetch_strobe", state, 0);
            bus_ack    = (i == w);
            instr_done = (i != w);
            bus_rdata  = (i == w) ? b : ~b;
            if (i == w) begin
                model_instr[8*lane +: 8] = b;
                if (lane == 3) exp_q.push_back(model_instr);
            end
            tick();
        end
        bus_ack = 1'b0;
        instr_done = 1'b0;
        chk("fetch_instr", instr, model_instr);
    endtask

    task automatic fetch_word(input logic [31:0] word, input int w);
        for (int l = 0; l < 4; l++) fetch_byte(l, word[8*l +: 8], w);
    endtask

    task automatic enter_exec();
        chk("inc_state", cpu_state, 1);
        chk("inc_strobe", state, 1);
        chk("inc_req", bus_req, 0);
        tick();
        chk("exec_state", cpu_state, 2);
        chk("exec_strobe", state, 0);
        chk("exec_stg0", instr_stg, 0);
    endtask

    task automatic retire();
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        chk("ret_state", cpu_state, 0);
        chk("ret_stg", instr_stg, 0);
        chk("ret_lane", bus_lane, 0);
        chk("ret_req", bus_req, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[11] = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};

        // 1: reset then zero-wait fetch of addi a0,x0,1
        tick();
        do_reset(2);
        fetch_word(32'h00100513, 0);
        enter_exec();
        retire();

        // 2: three wait cycles per byte, then a second word with one wait
        fetch_word(32'h00100513, 3);
        chk("wait_fault", fault, 0);
        enter_exec();
        retire();
        fetch_word(32'hDEADBEEF, 1);
        enter_exec();

        // 3: stage holding; final cycle has stg_wait and instr_done together
        for (int i = 0; i < 11; i++) begin
            chk("stg_seq", instr_stg, seq[i]);
            chk("stg_cpu_state", cpu_state, 2);
            chk("stg_instr", instr, 32'hDEADBEEF);
            stg_wait   = (i < 10) ? (seq[i+1] == seq[i]) : 1'b1;
            instr_done = (i == 10);
            bus_ack    = (i % 2 == 1);
            tick();
        end
        stg_wait = 1'b0;
        instr_done = 1'b0;
        bus_ack = 1'b0;
        chk("hold_ret_state", cpu_state, 0);
        chk("hold_ret_stg", instr_stg, 0);
        chk("hold_ret_lane", bus_lane, 0);

        // 4: stage overflow on an opcode-0 word
        fetch_word(32'hA5A5A500, 0);
        enter_exec();
        for (int i = 0; i < 8; i++) begin
            chk("ovf_stg", instr_stg, i);
            chk("ovf_cpu_state", cpu_state, 2);
            tick();
        end
        chk("ovf_fault_state", cpu_state, 15);
        chk("ovf_fault", fault, 1);
        chk("ovf_req", bus_req, 0);
        for (int i = 0; i < 100; i++) begin
            bus_ack    = (i % 2 == 0);
            instr_done = (i % 3 == 0);
            stg_wait   = (i % 5 == 0);
            bus_rdata  = 8'(i);
            tick();
            chk("sticky_state", cpu_state, 15);
            chk("sticky_fault", fault, 1);
            chk("sticky_instr", instr, 32'hA5A5A500);
            chk("sticky_stg", instr_stg, 7);
            chk("sticky_req", bus_req, 0);
            chk("sticky_strobe", state, 0);
        end

        // 6b: reset out of FAULT, then 5: bus timeout with ack held low
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            chk("tmo_state", cpu_state, 0);
            chk("tmo_req", bus_req, 1);
            tick();
        end
        chk("tmo_fault_state", cpu_state, 15);
        chk("tmo_fault", fault, 1);
        chk("tmo_req_low", bus_req, 0);
        tick();
        chk("tmo_req_stays_low", bus_req, 0);

        // 6b continued: refetch from lane 0 after leaving FAULT
        do_reset(1);
        fetch_word(32'h12345678, 0);
        enter_exec();
        retire();

        // 6a: reset mid-fetch at lane 2, ack asserted during reset
        fetch_byte(0, 8'h0D, 0);
        fetch_byte(1, 8'hF0, 1);
        chk("mid_lane", bus_lane, 2);
        bus_ack = 1'b1;
        bus_rdata = 8'h77;
        do_reset(1);
        fetch_word(32'hCAFEF00D, 0);
        enter_exec();
        retire();

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
